// File: rtl/clock_pkg.sv
// clock_pkg: shared state, limit and field-encoding definitions for the clock controller
package clock_pkg;
  typedef enum logic [1:0] {RUN, SET_HOURS, SET_MINUTES} state_t;
  localparam logic [5:0] MAX_SECONDS = 6'd59;
  localparam logic [5:0] MAX_MINUTES = 6'd59;
  localparam logic [4:0] MAX_HOURS = 5'd23;
  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOURS = 2'd1;
  localparam logic [1:0] FIELD_MINUTES = 2'd2;
  function automatic logic [1:0] field_of(state_t s);
    return s == SET_HOURS ? FIELD_HOURS : s == SET_MINUTES ? FIELD_MINUTES : FIELD_NONE;
  endfunction
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: synchronize, debounce and edge-detect one raw push button
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic sync1_q, sync2_q, level_q, level_d, press_q, differ, done;
  logic [CW-1:0] cnt_q, cnt_d;
  // accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles
  always_comb begin
    differ = sync2_q != level_q;
    done = differ && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    cnt_d = (differ && !done) ? cnt_q + CW'(1) : '0;
    level_d = done ? sync2_q : level_q;
  end
  // synchronizer, debounce state and registered rising-edge pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q <= cnt_d;
      press_q <= level_d & ~level_q;
    end
  end
  assign level_o = level_q;
  assign press_o = press_q;
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: two-button time-setting mode controller with auto-repeat, blink and load strobe
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY = 2,
  parameter int REPEAT_RATE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tc_time_base,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [5:0] q_minutes,
  input  logic [4:0] q_hours,
  output logic       tick_en,
  output logic       load,
  output logic [4:0] load_hours,
  output logic [5:0] load_minutes,
  output logic [5:0] load_seconds,
  output logic [1:0] edit_field,
  output logic       blink
);
  state_t state_q, state_d;
  logic [4:0] edit_h_q, edit_h_d;
  logic [5:0] edit_m_q, edit_m_d;
  logic [7:0] hold_q, hold_d, hold_nxt, limit;
  logic rep_q, rep_d, tog_q, tog_d, load_q, load_d;
  logic mode_press, inc_press, inc_lvl, mode_lvl_unused;
  logic setting, held, fire, step;
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .reset(reset), .btn_i(btn_mode), .level_o(mode_lvl_unused), .press_o(mode_press)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .reset(reset), .btn_i(btn_inc), .level_o(inc_lvl), .press_o(inc_press)
  );
  // next state, edit registers, auto-repeat counter and blink toggle; mode press beats inc
  always_comb begin
    setting = state_q != RUN;
    held = setting & inc_lvl & ~mode_press;
    limit = rep_q ? 8'(REPEAT_RATE) : 8'(REPEAT_DELAY);
    hold_nxt = hold_q + 8'd1;
    fire = held & tc_time_base & (hold_nxt == limit);
    step = setting & ~mode_press & (inc_press | fire);
    state_d = !mode_press ? state_q : state_q == RUN ? SET_HOURS : state_q == SET_HOURS ? SET_MINUTES : RUN;
    edit_h_d = (mode_press && state_q == RUN) ? q_hours :
               (step && state_q == SET_HOURS) ? (edit_h_q == MAX_HOURS ? 5'd0 : edit_h_q + 5'd1) : edit_h_q;
    edit_m_d = (mode_press && state_q == RUN) ? q_minutes :
               (step && state_q == SET_MINUTES) ? (edit_m_q == MAX_MINUTES ? 6'd0 : edit_m_q + 6'd1) : edit_m_q;
    hold_d = !held ? 8'd0 : !tc_time_base ? hold_q : fire ? 8'd0 : hold_nxt;
    rep_d = held & (fire | rep_q);
    tog_d = (state_d == RUN || (inc_press && !mode_press)) ? 1'b0 : tc_time_base ? ~tog_q : tog_q;
    load_d = mode_press & (state_q == SET_MINUTES);
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      edit_h_q <= '0;
      edit_m_q <= '0;
      hold_q <= '0;
      rep_q <= 1'b0;
      tog_q <= 1'b0;
      load_q <= 1'b0;
    end else begin
      state_q <= state_d;
      edit_h_q <= edit_h_d;
      edit_m_q <= edit_m_d;
      hold_q <= hold_d;
      rep_q <= rep_d;
      tog_q <= tog_d;
      load_q <= load_d;
    end
  end
  assign tick_en = tc_time_base & (state_q == RUN);
  assign load = load_q;
  assign load_hours = edit_h_q;
  assign load_minutes = edit_m_q;
  assign load_seconds = '0;
  assign edit_field = field_of(state_q);
  assign blink = tog_q & (state_q != RUN);
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: table-driven and directed checks of the time-setting controller
module tb_time_set_ctrl;
  logic clk = 1'b0, reset = 1'b1, tc = 1'b0, bm = 1'b0, bi = 1'b0;
  logic [5:0] qm = '0;
  logic [4:0] qh = '0;
  logic tick_en, load, blink;
  logic [4:0] load_hours;
  logic [5:0] load_minutes, load_seconds;
  logic [1:0] edit_field;
  int checks = 0, errors = 0, load_cnt = 0;
  logic [4:0] cap_h = '0;
  logic [5:0] cap_m = '0, cap_s = '1;
  typedef struct {
    int op;
    logic [4:0] qh;
    logic [5:0] qm;
    int fld;
    int lh;
    int lm;
    int te;
    int loads;
  } vec_t;
  vec_t tbl[17];

  time_set_ctrl #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(2), .REPEAT_RATE(1)) dut (
    .clk(clk), .reset(reset), .tc_time_base(tc), .btn_mode(bm), .btn_inc(bi),
    .q_minutes(qm), .q_hours(qh), .tick_en(tick_en), .load(load),
    .load_hours(load_hours), .load_minutes(load_minutes), .load_seconds(load_seconds),
    .edit_field(edit_field), .blink(blink)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load === 1'b1) begin
    load_cnt++;
    cap_h = load_hours;
    cap_m = load_minutes;
    cap_s = load_seconds;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int which);
    bm = (which != 1);
    bi = (which != 0);
    cycles(12);
    bm = 1'b0;
    bi = 1'b0;
    cycles(12);
  endtask

  task automatic tick(output logic te);
    tc = 1'b1;
    #2 te = tick_en;
    cycles(1);
    tc = 1'b0;
    cycles(2);
  endtask

  initial begin
    logic te;
    int n;
    tbl[0]  = '{0, 5'd10, 6'd15, 1, 10, 15, 0, 0};
    tbl[1]  = '{2, 5'd10, 6'd15, 1, 10, 15, 0, 0};
    tbl[2]  = '{1, 5'd10, 6'd15, 1, 11, 15, 0, 0};
    tbl[3]  = '{1, 5'd10, 6'd15, 1, 12, 15, 0, 0};
    tbl[4]  = '{1, 5'd10, 6'd15, 1, 13, 15, 0, 0};
    tbl[5]  = '{0, 5'd10, 6'd15, 2, 13, 15, 0, 0};
    tbl[6]  = '{1, 5'd10, 6'd15, 2, 13, 16, 0, 0};
    tbl[7]  = '{1, 5'd10, 6'd15, 2, 13, 17, 0, 0};
    tbl[8]  = '{2, 5'd10, 6'd15, 2, 13, 17, 0, 0};
    tbl[9]  = '{0, 5'd10, 6'd15, 0, 13, 17, 0, 1};
    tbl[10] = '{2, 5'd10, 6'd15, 0, 13, 17, 1, 1};
    tbl[11] = '{1, 5'd10, 6'd15, 0, 13, 17, 0, 1};
    tbl[12] = '{0, 5'd23, 6'd59, 1, 23, 59, 0, 1};
    tbl[13] = '{1, 5'd23, 6'd59, 1, 0, 59, 0, 1};
    tbl[14] = '{0, 5'd23, 6'd59, 2, 0, 59, 0, 1};
    tbl[15] = '{1, 5'd23, 6'd59, 2, 0, 0, 0, 1};
    tbl[16] = '{0, 5'd23, 6'd59, 0, 0, 0, 0, 2};
    cycles(3);
    check("reset_field", edit_field, 0);
    check("reset_load", load, 0);
    check("reset_blink", blink, 0);
    check("reset_tick_en", tick_en, 0);
    check("reset_lh", load_hours, 0);
    check("reset_lm", load_minutes, 0);
    check("reset_ls", load_seconds, 0);
    reset = 1'b0;
    cycles(2);
    for (int i = 0; i < 17; i++) begin
      qh = tbl[i].qh;
      qm = tbl[i].qm;
      if (tbl[i].op == 2) begin
        tick(te);
        check($sformatf("row%0d_tick_en", i), te, tbl[i].te);
      end else press(tbl[i].op);
      check($sformatf("row%0d_field", i), edit_field, tbl[i].fld);
      check($sformatf("row%0d_lh", i), load_hours, tbl[i].lh);
      check($sformatf("row%0d_lm", i), load_minutes, tbl[i].lm);
      check($sformatf("row%0d_loads", i), load_cnt, tbl[i].loads);
      if (tbl[i].op == 0 && tbl[i].fld == 0) begin
        check($sformatf("row%0d_cap_h", i), cap_h, tbl[i].lh);
        check($sformatf("row%0d_cap_m", i), cap_m, tbl[i].lm);
        check($sformatf("row%0d_cap_s", i), cap_s, 0);
      end
    end
    qh = 5'd4;
    qm = 6'd5;
    press(0);
    check("bounce_field", edit_field, 1);
    check("bounce_lh0", load_hours, 4);
    tick(te);
    check("blink_on_tick", blink, 1);
    bi = 1'b1;
    cycles(1);
    bi = 1'b0;
    cycles(1);
    bi = 1'b1;
    cycles(10);
    bi = 1'b0;
    cycles(12);
    check("bounce_lh", load_hours, 5);
    check("blink_after_inc", blink, 0);
    press(2);
    check("both_field", edit_field, 2);
    check("both_lh", load_hours, 5);
    check("both_lm", load_minutes, 5);
    bi = 1'b1;
    cycles(12);
    check("repeat_press", load_minutes, 6);
    for (int k = 0; k < 5; k++) begin
      tc = 1'b1;
      cycles(1);
      tc = 1'b0;
      cycles(2);
    end
    check("repeat_5ticks", load_minutes, 10);
    bi = 1'b0;
    cycles(12);
    check("repeat_release", load_minutes, 10);
    press(0);
    check("repeat_load_cnt", load_cnt, 3);
    check("repeat_cap_h", cap_h, 5);
    check("repeat_cap_m", cap_m, 10);
    qh = 5'd1;
    qm = 6'd30;
    press(0);
    press(0);
    check("pre_reset_field", edit_field, 2);
    check("pre_reset_lm", load_minutes, 30);
    n = load_cnt;
    #2 reset = 1'b1;
    #1;
    check("async_reset_field", edit_field, 0);
    check("async_reset_lm", load_minutes, 0);
    check("async_reset_lh", load_hours, 0);
    check("async_reset_load", load, 0);
    check("async_reset_blink", blink, 0);
    cycles(2);
    reset = 1'b0;
    cycles(5);
    check("reset_no_load", load_cnt, n);
    check("post_reset_field", edit_field, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
